// File: rtl/bloom_pkg.sv
//------------------------------------------------------------------------------
// Module   : bloom_pkg
// Purpose  : Shared op encodings, FSM state type and default parameters for the
//            Bloom filter custom-instruction controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bloom_pkg;

  // Default sizing
  localparam int DEFAULT_NUM_WORDS = 32;
  localparam int DEFAULT_TIMEOUT   = 16;
  localparam int DEFAULT_CNT_W     = 16;

  // Custom-instruction op encodings; every other value is illegal
  localparam logic [4:0] BLOOM_OP_INSERT = 5'b00001;
  localparam logic [4:0] BLOOM_OP_CLEAR  = 5'b00011;
  localparam logic [4:0] BLOOM_OP_CHECK  = 5'b00100;
  localparam logic [4:0] BLOOM_OP_COUNT  = 5'b00101;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_RESP  = 3'd4
  } bloom_state_e;

endpackage : bloom_pkg

`default_nettype wire

// File: rtl/bloom_ctrl.sv
//------------------------------------------------------------------------------
// Module   : bloom_ctrl
// Purpose  : Sequencer between the EX-stage custom-instruction port and the
//            Bloom filter datapath: insert/check command issue with completion
//            wait and timeout, word-by-word clear sweep, saturating insert
//            counter, kill and illegal-op handling.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bloom_ctrl #(
  parameter int NUM_WORDS = bloom_pkg::DEFAULT_NUM_WORDS,
  parameter int TIMEOUT   = bloom_pkg::DEFAULT_TIMEOUT,
  parameter int CNT_W     = bloom_pkg::DEFAULT_CNT_W,
  localparam int ADDR_W   = $clog2(NUM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              custom_en_i,
  input  logic [4:0]        custom_op_i,
  input  logic [31:0]       custom_rs1_i,
  input  logic              custom_kill_i,
  output logic              custom_ready_o,
  output logic              custom_valid_o,
  output logic [31:0]       custom_result_o,
  output logic              custom_err_o,
  output logic [31:0]       bloom_data_o,
  output logic              bloom_insert_o,
  output logic              bloom_check_o,
  input  logic              bloom_done_i,
  input  logic              bloom_match_i,
  output logic              bloom_clr_o,
  output logic [ADDR_W-1:0] bloom_clr_addr_o,
  output logic              busy_o
);

  import bloom_pkg::*;

  // The shared counter must hold both a clear address and a timeout count
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CTR_W = (ADDR_W > TMO_W) ? ADDR_W : TMO_W;

  bloom_state_e     r_state;
  bloom_state_e     w_state_nxt;

  logic [4:0]       r_op;
  logic [31:0]      r_data;
  logic [31:0]      r_result;
  logic             r_err;
  logic             r_killed;
  logic [CTR_W-1:0] r_ctr;
  logic [CNT_W-1:0] r_ins_cnt;

  logic             w_accept;
  logic             w_timeout;
  logic             w_last_word;
  logic             w_is_insert;
  logic             w_is_check;

  assign w_accept    = (r_state == ST_IDLE) && custom_en_i && !custom_kill_i;
  assign w_timeout   = (r_ctr == CTR_W'(TIMEOUT - 1));
  assign w_last_word = (r_ctr[ADDR_W-1:0] == ADDR_W'(NUM_WORDS - 1));
  assign w_is_insert = (r_op == BLOOM_OP_INSERT);
  assign w_is_check  = (r_op == BLOOM_OP_CHECK);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state output drive
  always_comb begin
    w_state_nxt      = r_state;
    custom_ready_o   = 1'b0;
    custom_valid_o   = 1'b0;
    custom_result_o  = 32'd0;
    custom_err_o     = 1'b0;
    bloom_insert_o   = 1'b0;
    bloom_check_o    = 1'b0;
    bloom_clr_o      = 1'b0;
    bloom_clr_addr_o = '0;
    busy_o           = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        custom_ready_o = 1'b1;
        if (w_accept) begin
          case (custom_op_i)
            BLOOM_OP_INSERT, BLOOM_OP_CHECK: w_state_nxt = ST_ISSUE;
            BLOOM_OP_CLEAR:                  w_state_nxt = ST_CLEAR;
            default:                         w_state_nxt = ST_RESP;
          endcase
        end
      end
      ST_ISSUE: begin
        bloom_insert_o = w_is_insert;
        bloom_check_o  = w_is_check;
        w_state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bloom_done_i || w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_CLEAR: begin
        bloom_clr_o      = 1'b1;
        bloom_clr_addr_o = r_ctr[ADDR_W-1:0];
        if (w_last_word) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // A kill in this very cycle still suppresses the strobe
        custom_valid_o  = !r_killed && !custom_kill_i;
        custom_result_o = custom_valid_o ? r_result : 32'd0;
        custom_err_o    = custom_valid_o && r_err;
        w_state_nxt     = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand/result capture, shared timeout/clear counter, kill tracking and insert counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op      <= 5'd0;
      r_data    <= 32'd0;
      r_result  <= 32'd0;
      r_err     <= 1'b0;
      r_killed  <= 1'b0;
      r_ctr     <= '0;
      r_ins_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op     <= custom_op_i;
            r_data   <= custom_rs1_i;
            r_killed <= 1'b0;
            r_ctr    <= '0;
            r_result <= (custom_op_i == BLOOM_OP_COUNT) ? 32'(r_ins_cnt) : 32'd0;
            r_err    <= !((custom_op_i == BLOOM_OP_INSERT) || (custom_op_i == BLOOM_OP_CLEAR) ||
                          (custom_op_i == BLOOM_OP_CHECK)  || (custom_op_i == BLOOM_OP_COUNT));
          end
        end
        ST_ISSUE: begin
          r_ctr <= '0;
          if (custom_kill_i) r_killed <= 1'b1;
        end
        ST_WAIT: begin
          if (custom_kill_i) r_killed <= 1'b1;
          if (bloom_done_i) begin
            r_result <= {31'd0, w_is_check && bloom_match_i};
            r_err    <= 1'b0;
            if (w_is_insert && (r_ins_cnt != {CNT_W{1'b1}})) begin
              r_ins_cnt <= r_ins_cnt + CNT_W'(1);
            end
          end else if (w_timeout) begin
            r_result <= 32'd0;
            r_err    <= 1'b1;
          end else begin
            r_ctr <= r_ctr + CTR_W'(1);
          end
        end
        ST_CLEAR: begin
          if (custom_kill_i) r_killed <= 1'b1;
          r_ctr <= r_ctr + CTR_W'(1);
          if (w_last_word) begin
            r_ins_cnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bloom_data_o = r_data;

endmodule : bloom_ctrl

`default_nettype wire

// File: tb/tb_bloom_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_bloom_ctrl
// Purpose  : Directed self-checking bench for bloom_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bloom_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        custom_en_i;
  logic [4:0]  custom_op_i;
  logic [31:0] custom_rs1_i;
  logic        custom_kill_i;
  logic        custom_ready_o;
  logic        custom_valid_o;
  logic [31:0] custom_result_o;
  logic        custom_err_o;
  logic [31:0] bloom_data_o;
  logic        bloom_insert_o;
  logic        bloom_check_o;
  logic        bloom_done_i;
  logic        bloom_match_i;
  logic        bloom_clr_o;
  logic [4:0]  bloom_clr_addr_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  bloom_ctrl dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .custom_en_i      (custom_en_i),
    .custom_op_i      (custom_op_i),
    .custom_rs1_i     (custom_rs1_i),
    .custom_kill_i    (custom_kill_i),
    .custom_ready_o   (custom_ready_o),
    .custom_valid_o   (custom_valid_o),
    .custom_result_o  (custom_result_o),
    .custom_err_o     (custom_err_o),
    .bloom_data_o     (bloom_data_o),
    .bloom_insert_o   (bloom_insert_o),
    .bloom_check_o    (bloom_check_o),
    .bloom_done_i     (bloom_done_i),
    .bloom_match_i    (bloom_match_i),
    .bloom_clr_o      (bloom_clr_o),
    .bloom_clr_addr_o (bloom_clr_addr_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle; sample and drive 1 time unit after the rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle (the cycle T), then drop en
  task automatic issue(input logic [4:0] op, input logic [31:0] rs1);
    custom_en_i  = 1'b1;
    custom_op_i  = op;
    custom_rs1_i = rs1;
    step();
    custom_en_i  = 1'b0;
  endtask

  initial begin
    rst_ni        = 1'b0;
    custom_en_i   = 1'b0;
    custom_op_i   = 5'd0;
    custom_rs1_i  = 32'd0;
    custom_kill_i = 1'b0;
    bloom_done_i  = 1'b0;
    bloom_match_i = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_ready", {31'd0, custom_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, custom_valid_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o},         32'd0);
    chk("rst_data",  bloom_data_o,            32'd0);
    chk("rst_clr",   {31'd0, bloom_clr_o},    32'd0);
    rst_ni = 1'b1;
    step();

    // Insert DEADBEEF, done three cycles after the pulse
    issue(5'b00001, 32'hDEADBEEF);                                     // now T+1
    chk("ins_pulse",  {31'd0, bloom_insert_o}, 32'd1);
    chk("ins_chk0",   {31'd0, bloom_check_o},  32'd0);
    chk("ins_data",   bloom_data_o,            32'hDEADBEEF);
    chk("ins_ready0", {31'd0, custom_ready_o}, 32'd0);
    step();                                                            // T+2
    chk("ins_pulse1", {31'd0, bloom_insert_o}, 32'd0);
    step();                                                            // T+3
    step();                                                            // T+4
    chk("ins_novalid", {31'd0, custom_valid_o}, 32'd0);
    bloom_done_i = 1'b1;
    step();                                                            // T+5
    bloom_done_i = 1'b0;
    chk("ins_valid",  {31'd0, custom_valid_o}, 32'd1);
    chk("ins_result", custom_result_o,         32'd0);
    chk("ins_err",    {31'd0, custom_err_o},   32'd0);
    step();
    chk("ins_idle",   {31'd0, custom_ready_o}, 32'd1);
    chk("ins_hold",   bloom_data_o,            32'hDEADBEEF);

    // Count after one insert
    issue(5'b00101, 32'd0);
    chk("cnt1_valid",  {31'd0, custom_valid_o}, 32'd1);
    chk("cnt1_result", custom_result_o,         32'd1);
    step();

    // Check with match=1 at T+2
    issue(5'b00100, 32'h12345678);                                     // T+1
    chk("chk_pulse", {31'd0, bloom_check_o}, 32'd1);
    step();                                                            // T+2
    bloom_done_i = 1'b1; bloom_match_i = 1'b1;
    step();                                                            // T+3
    bloom_done_i = 1'b0; bloom_match_i = 1'b0;
    chk("chk1_valid",  {31'd0, custom_valid_o}, 32'd1);
    chk("chk1_result", custom_result_o,         32'd1);
    chk("chk1_err",    {31'd0, custom_err_o},   32'd0);
    step();

    // Check with match=0
    issue(5'b00100, 32'h0000CAFE);
    step();
    bloom_done_i = 1'b1; bloom_match_i = 1'b0;
    step();
    bloom_done_i = 1'b0;
    chk("chk0_valid",  {31'd0, custom_valid_o}, 32'd1);
    chk("chk0_result", custom_result_o,         32'd0);
    step();

    // Clear sweep across 32 words
    issue(5'b00011, 32'd0);                                            // T+1
    for (int i = 0; i < 32; i++) begin
      chk("clr_en",   {31'd0, bloom_clr_o},       32'd1);
      chk("clr_addr", {27'd0, bloom_clr_addr_o},  i);
      chk("clr_nv",   {31'd0, custom_valid_o},    32'd0);
      step();
    end                                                                // T+33
    chk("clr_off",    {31'd0, bloom_clr_o},    32'd0);
    chk("clr_valid",  {31'd0, custom_valid_o}, 32'd1);
    chk("clr_result", custom_result_o,         32'd0);
    step();
    issue(5'b00101, 32'd0);
    chk("cnt0_result", custom_result_o, 32'd0);
    step();

    // Check without done: timeout
    issue(5'b00100, 32'h55AA55AA);                                     // T+1
    for (int i = 0; i < 16; i++) step();                               // T+17
    chk("tmo_pending", {31'd0, custom_valid_o}, 32'd0);
    chk("tmo_busy",    {31'd0, busy_o},         32'd1);
    step();                                                            // T+18
    chk("tmo_valid",  {31'd0, custom_valid_o}, 32'd1);
    chk("tmo_err",    {31'd0, custom_err_o},   32'd1);
    chk("tmo_result", custom_result_o,         32'd0);
    step();
    bloom_done_i = 1'b1; bloom_match_i = 1'b1;
    chk("tmo_ready", {31'd0, custom_ready_o}, 32'd1);
    step();
    bloom_done_i = 1'b0; bloom_match_i = 1'b0;
    chk("late_novalid", {31'd0, custom_valid_o}, 32'd0);
    chk("late_ready",   {31'd0, custom_ready_o}, 32'd1);

    // Illegal op
    issue(5'b00010, 32'hFFFFFFFF);
    chk("ill_valid",  {31'd0, custom_valid_o}, 32'd1);
    chk("ill_err",    {31'd0, custom_err_o},   32'd1);
    chk("ill_result", custom_result_o,         32'd0);
    chk("ill_dp",     {29'd0, bloom_insert_o, bloom_check_o, bloom_clr_o}, 32'd0);
    step();

    // Kill in IDLE with en: nothing accepted
    custom_kill_i = 1'b1;
    issue(5'b00101, 32'd0);
    custom_kill_i = 1'b0;
    chk("kidle_busy",  {31'd0, busy_o},         32'd0);
    chk("kidle_valid", {31'd0, custom_valid_o}, 32'd0);

    // Kill during WAIT of an insert
    issue(5'b00001, 32'h0BADF00D);                                     // T+1
    step();                                                            // T+2
    custom_kill_i = 1'b1;
    step();                                                            // T+3
    custom_kill_i = 1'b0;
    step();                                                            // T+4
    bloom_done_i = 1'b1;
    step();                                                            // T+5 RESP
    bloom_done_i = 1'b0;
    chk("kill_novalid", {31'd0, custom_valid_o}, 32'd0);
    chk("kill_busy",    {31'd0, busy_o},         32'd1);
    step();
    chk("kill_ready", {31'd0, custom_ready_o}, 32'd1);
    issue(5'b00101, 32'd0);
    chk("kill_cnt", custom_result_o, 32'd1);
    step();

    // Reset during clear at address 10
    issue(5'b00011, 32'd0);                                            // addr 0
    for (int i = 0; i < 10; i++) step();                               // addr 10
    chk("rclr_addr", {27'd0, bloom_clr_addr_o}, 32'd10);
    rst_ni = 1'b0;
    #1;
    chk("rclr_clr",   {31'd0, bloom_clr_o},       32'd0);
    chk("rclr_addr0", {27'd0, bloom_clr_addr_o},  32'd0);
    chk("rclr_busy",  {31'd0, busy_o},            32'd0);
    chk("rclr_data",  bloom_data_o,               32'd0);
    step();
    rst_ni = 1'b1;
    step();
    chk("rclr_ready", {31'd0, custom_ready_o}, 32'd1);
    issue(5'b00101, 32'd0);
    chk("rclr_cnt", custom_result_o, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bloom_ctrl

`default_nettype wire

// File: doc/bloom_ctrl.md
Name: bloom_ctrl

Overview:
- Sequencer between the core's EX-stage custom-instruction interface and the Bloom filter datapath.
- Decodes custom ops: insert, check, clear, count.
- Issues one-cycle command pulses to the filter, waits for its completion handshake, and sweeps a word-by-word clear.
- Returns a single-cycle result/valid to EX, with flush (kill), timeout and illegal-op handling.

Parameters:
- NUM_WORDS, 32, number of filter storage words cleared by the clear op; power of two, ≥2.
- TIMEOUT, 16, maximum WAIT cycles before an insert/check is aborted with error; ≥2.
- CNT_W, 16, width of the saturating insert counter; ≤32.
- ADDR_W (localparam), $clog2(NUM_WORDS), clear address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- custom_en_i  in  1  EX request valid
- custom_op_i  in  5  op: 5'b00001 insert, 5'b00011 clear, 5'b00100 check, 5'b00101 count; all other values illegal
- custom_rs1_i  in  32  operand (element to insert/check)
- custom_kill_i  in  1  EX flush of the in-flight op
- custom_ready_o  out  1  controller idle, can accept
- custom_valid_o  out  1  one-cycle result strobe
- custom_result_o  out  32  result; valid only with custom_valid_o
- custom_err_o  out  1  error qualifier of custom_valid_o
- bloom_data_o  out  32  latched operand to the filter
- bloom_insert_o  out  1  one-cycle insert command
- bloom_check_o  out  1  one-cycle check command
- bloom_done_i  in  1  filter completion strobe
- bloom_match_i  in  1  check result; valid with bloom_done_i
- bloom_clr_o  out  1  clear-word enable
- bloom_clr_addr_o  out  ADDR_W  word being cleared
- busy_o  out  1  not IDLE

Behaviour:
- Reset (rst_ni low, any state):
  - state to IDLE.
  - custom_ready_o=1; all other outputs 0.
  - insert counter 0; bloom_data_o 0.
- FSM states: IDLE, ISSUE, WAIT, CLEAR, RESP.
- Accept rule: transfer when custom_en_i && custom_ready_o && !custom_kill_i at cycle T.
  - rs1 and op are latched at T.
  - custom_ready_o=1 only in IDLE.
- Insert/check:
  - T+1 ISSUE: matching command pulses for exactly 1 cycle.
  - Then WAIT: samples bloom_done_i from T+2 onward. A done seen in ISSUE is ignored; the filter takes ≥1 cycle.
  - Done at cycle D → RESP at D+1: custom_valid_o=1.
  - Check result = {31'b0, bloom_match_i captured at D}. Insert result = 0.
  - Insert done increments the counter, saturating at all-ones.
- Timeout: if TIMEOUT WAIT cycles elapse without done → RESP with err=1, result 0. The counter is not incremented. A late done afterwards is ignored.
- Clear:
  - bloom_clr_o=1 for cycles T+1..T+NUM_WORDS, with addr 0..NUM_WORDS-1 ascending.
  - Counter zeroes on the last clear cycle.
  - RESP at T+NUM_WORDS+1, result 0.
- Count: RESP at T+1, result = zero-extended counter.
- Illegal op: RESP at T+1 with err=1, result 0. No datapath activity.
- RESP lasts 1 cycle, then IDLE. Back-to-back accept is possible in the cycle after RESP.
- bloom_data_o holds the latched operand from ISSUE until the next accept.
- Kill:
  - Asserted in ISSUE/WAIT/CLEAR/RESP: the response is suppressed (no custom_valid_o), but the datapath op runs to completion.
  - Clear always sweeps all words, so the filter is never left partially cleared.
  - Insert-count update still occurs for a killed insert that completes.
  - Kill coincident with done: response suppressed.
  - Kill in IDLE with en: no accept.
- bloom_done_i in IDLE/CLEAR/RESP: ignored.
- Reset mid-operation: immediate IDLE. The filter contents are undefined until a clear op is run; software must issue one.

Decomposition:
- Shared package bloom_pkg holds:
  - op encodings: BLOOM_OP_INSERT, BLOOM_OP_CLEAR, BLOOM_OP_CHECK, BLOOM_OP_COUNT;
  - the FSM state enum;
  - default parameters.
- No sub-module. The timeout and clear-address counters are shared in one register because the states are exclusive.

Test Plan:
- Insert rs1=32'hDEADBEEF, done returned 3 cycles after pulse → bloom_insert_o pulse at T+1, valid at T+5 with result 0; count op then returns 1.
- Check with done+match=1 at T+2 → valid at T+3, result 32'h1, err 0. Repeat with match=0 → result 0.
- Clear with NUM_WORDS=32 → clr_o high 32 cycles, addr 0..31, valid at T+33; subsequent count returns 0.
- Check with no done → valid with err=1 at T+1+TIMEOUT+1; a late done is ignored and ready stays correct.
- Op 5'b00010 → valid+err at T+1, no bloom_* activity. Kill during WAIT of an insert → no valid, counter still increments on done.
- rst_ni low during CLEAR at address 10 → outputs 0 immediately, ready=1 on release, counter 0.
